// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the MEM stage.
// Turns an EX/MEM load/store into a registered memory request and holds the
// pipeline while the access is outstanding. Misaligned accesses are
// rejected in a single cycle. Silent memories are reported as a bus error
// after TIMEOUT wait cycles.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no access outstanding; examine EX/MEM each cycle
//   S_WAIT | request on the bus, waiting for mem_ack or the timeout
//   S_DONE | result in read_data; instruction advances into MEM/WB
module dmem_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        em_valid,
   input  logic        em_memread,
   input  logic        em_memwrite,
   input  logic [31:0] em_addr,
   input  logic [31:0] em_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        mw_bubble,
   output logic        align_exc,
   output logic        bus_err
);

   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [31:0]   r_read_data;
   logic          r_bus_err;

   logic          w_mem_op;
   logic          w_misaligned;
   logic          w_issue;
   logic          w_ack_done;
   logic          w_timeout;
   logic          w_stall;
   logic          w_bubble;
   logic          w_align;

   // A store wins when both read and write are flagged: mem_we takes em_memwrite.
   assign w_mem_op     = em_valid & (em_memread | em_memwrite);
   assign w_misaligned = (em_addr[1:0] != 2'b00);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and pipeline-control decode; ack beats timeout in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_ack_done  = 1'b0;
      w_timeout   = 1'b0;
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
      w_align     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               if (w_misaligned) begin
                  w_align  = 1'b1;
                  w_bubble = 1'b1;
               end else begin
                  w_issue     = 1'b1;
                  w_stall     = 1'b1;
                  w_bubble    = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (mem_ack) begin
               w_ack_done  = 1'b1;
               w_state_nxt = S_DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bus request, wait counter, load result and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_read_data <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
         if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= em_memwrite;
            r_mem_addr  <= {em_addr[31:2], 2'b00};
            r_mem_wdata <= em_wdata;
            r_cnt       <= '0;
         end else if (w_ack_done) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) r_read_data <= mem_rdata;
         end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_read_data <= '0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign read_data = r_read_data;
   assign bus_err   = r_bus_err;
   assign stall     = w_stall;
   assign mw_bubble = w_bubble;
   assign align_exc = w_align;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios followed by random load/store
// traffic. Expectations come from a transaction-level model: an aligned
// access costs 1 + (WAIT cycles) stall cycles, where the WAIT count is the
// ack cycle or TIMEOUT when no ack arrives in time.
module tb_dmem_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk         = 1'b0;
   logic        rst_n       = 1'b0;
   logic        em_valid    = 1'b0;
   logic        em_memread  = 1'b0;
   logic        em_memwrite = 1'b0;
   logic [31:0] em_addr     = '0;
   logic [31:0] em_wdata    = '0;
   logic        mem_ack     = 1'b0;
   logic [31:0] mem_rdata   = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] read_data;
   logic        stall;
   logic        mw_bubble;
   logic        align_exc;
   logic        bus_err;

   int          total  = 0;
   int          bad    = 0;
   logic [31:0] exp_rd = '0;

   always #5 clk = ~clk;

   dmem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .em_valid    (em_valid),
      .em_memread  (em_memread),
      .em_memwrite (em_memwrite),
      .em_addr     (em_addr),
      .em_wdata    (em_wdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .read_data   (read_data),
      .stall       (stall),
      .mw_bubble   (mw_bubble),
      .align_exc   (align_exc),
      .bus_err     (bus_err)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Present one EX/MEM instruction, starting just after a rising edge.
   // ack_n: WAIT cycle (1-based) in which mem_ack is driven; >TIMEOUT means none in time.
   task automatic run_op(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdata, input int ack_n, input bit gap);
      logic is_mem, mis, to;
      int   nwait, cyc, nstall, nreq;
      is_mem      = v & (rd | wr);
      mis         = (a[1:0] != 2'b00);
      em_valid    = v;
      em_memread  = rd;
      em_memwrite = wr;
      em_addr     = a;
      em_wdata    = wd;
      mem_rdata   = $urandom;
      if (!is_mem || mis) begin
         mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check1("pass_stall", stall, 1'b0);
         check1("pass_bubble", mw_bubble, is_mem);
         check1("pass_align", align_exc, is_mem);
         check1("pass_req", mem_req, 1'b0);
         check32("pass_rdata", read_data, exp_rd);
         @(posedge clk); #1;
         em_valid = 1'b0;
         mem_ack  = 1'b0;
         @(negedge clk);
         check1("pass_noreq", mem_req, 1'b0);
         check1("pass_berr", bus_err, 1'b0);
         @(posedge clk); #1;
         return;
      end
      to     = !(ack_n >= 1 && ack_n <= TIMEOUT);
      nwait  = to ? TIMEOUT : ack_n;
      cyc    = 0;
      nstall = 0;
      nreq   = 0;
      while (1) begin
         if (cyc == ack_n)                mem_ack = 1'b1;
         else if (cyc == 0 || cyc > nwait) mem_ack = 1'($urandom_range(0, 1));
         else                             mem_ack = 1'b0;
         mem_rdata = (cyc == ack_n) ? rdata : $urandom;
         @(negedge clk);
         if (stall !== 1'b1) break;
         nstall++;
         if (mem_req === 1'b1) nreq++;
         if (cyc == 0) check1("idle_req", mem_req, 1'b0);
         if (cyc == 1) begin
            check1("req_on", mem_req, 1'b1);
            check1("req_we", mem_we, wr);
            check32("req_addr", mem_addr, {a[31:2], 2'b00});
            check32("req_wdata", mem_wdata, wd);
         end
         @(posedge clk); #1;
         cyc++;
         if (cyc > TIMEOUT + 8) begin
            check1("stall_bound", stall, 1'b0);
            break;
         end
      end
      if (to)       exp_rd = '0;
      else if (!wr) exp_rd = rdata;
      check32("stall_cycles", nstall, 1 + nwait);
      check32("req_cycles", nreq, nwait);
      check1("done_req", mem_req, 1'b0);
      check1("done_bubble", mw_bubble, 1'b0);
      check32("done_rdata", read_data, exp_rd);
      check1("done_berr", bus_err, to);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (gap) begin
         em_valid = 1'b0;
         mem_ack  = 1'($urandom_range(0, 1));
         @(negedge clk);
         check1("post_req", mem_req, 1'b0);
         check1("post_stall", stall, 1'b0);
         check1("post_berr", bus_err, 1'b0);
         check32("post_rdata", read_data, exp_rd);
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      // Reset values
      @(negedge clk);
      check1("rst_req", mem_req, 1'b0);
      check1("rst_we", mem_we, 1'b0);
      check32("rst_addr", mem_addr, 32'h0);
      check32("rst_wdata", mem_wdata, 32'h0);
      check32("rst_rdata", read_data, 32'h0);
      check1("rst_berr", bus_err, 1'b0);
      check1("rst_stall", stall, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Load 0x100, ack in first WAIT cycle
      run_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b1);
      // Store 0x204, ack in third WAIT cycle, read_data held
      run_op(1'b1, 1'b0, 1'b1, 32'h204, 32'h12345678, 32'hAAAA5555, 3, 1'b1);
      // Both read and write flagged: treated as a store
      run_op(1'b1, 1'b1, 1'b1, 32'h308, 32'hCAFEF00D, 32'h11112222, 2, 1'b1);
      // Misaligned load
      run_op(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 1, 1'b1);
      // Non-memory instruction
      run_op(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1, 1'b1);
      // Load with no ack: timeout
      run_op(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 999, 1'b1);
      // Reload a value, then ack and timeout in the same cycle: ack wins
      run_op(1'b1, 1'b1, 1'b0, 32'h504, 32'h0, 32'h0BADC0DE, TIMEOUT, 1'b1);
      // Back-to-back loads, no idle gap between them
      run_op(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h01234567, 1, 1'b0);
      run_op(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 32'h89ABCDEF, 1, 1'b1);

      // Reset in the second WAIT cycle, ack after release
      em_valid    = 1'b1;
      em_memread  = 1'b1;
      em_memwrite = 1'b0;
      em_addr     = 32'h40;
      mem_ack     = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check1("rstw_pre_req", mem_req, 1'b1);
      #2;
      rst_n    = 1'b0;
      em_valid = 1'b0;
      #1;
      check1("rstw_req", mem_req, 1'b0);
      check1("rstw_stall", stall, 1'b0);
      check32("rstw_rdata", read_data, 32'h0);
      exp_rd = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      check1("rstw_ack_stall", stall, 1'b0);
      check1("rstw_ack_req", mem_req, 1'b0);
      check1("rstw_ack_bubble", mw_bubble, 1'b0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check32("rstw_post_rdata", read_data, exp_rd);
      check1("rstw_post_berr", bus_err, 1'b0);
      check1("rstw_post_req", mem_req, 1'b0);
      @(posedge clk); #1;

      // Random traffic
      for (int k = 0; k < 40; k++) begin
         logic        v, rd, wr;
         logic [31:0] a;
         int          an;
         v  = ($urandom_range(0, 7) != 0);
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 5) == 0) an = TIMEOUT + int'($urandom_range(0, 3));
         else                           an = int'($urandom_range(1, 4));
         run_op(v, rd, wr, a, $urandom, $urandom, an, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning the maximum number of cycles spent waiting for mem_ack before a bus error is declared (legal range 2..255).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 em_valid  input  1  EX/MEM stage holds a valid instruction.
REQ-005 em_memread  input  1  EX/MEM instruction is a word load.
REQ-006 em_memwrite  input  1  EX/MEM instruction is a word store.
REQ-007 em_addr  input  32  byte address from EX/MEM ALU result.
REQ-008 em_wdata  input  32  store data from EX/MEM.
REQ-009 mem_req  output  1  registered request to data memory.
REQ-010 mem_we  output  1  registered write enable, qualified by mem_req.
REQ-011 mem_addr  output  32  registered word address to memory.
REQ-012 mem_wdata  output  32  registered store data.
REQ-013 mem_ack  input  1  memory completion strobe, one cycle.
REQ-014 mem_rdata  input  32  load data, valid when mem_ack=1.
REQ-015 read_data  output  32  registered load result presented to MEM/WB ReadData.
REQ-016 stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-017 mw_bubble  output  1  combinational; forces MEM/WB to load a bubble (RegWrite=0).
REQ-018 align_exc  output  1  combinational; misaligned access flag.
REQ-019 bus_err  output  1  registered one-cycle pulse on access timeout.

Function
REQ-020 mem_op SHALL be em_valid & (em_memread | em_memwrite); if both read and write are set, the operation SHALL be treated as a write.
REQ-021 The FSM SHALL have exactly three states, IDLE, WAIT and DONE, and a wait counter of width ceil(log2(TIMEOUT))+1 bits.
REQ-022 IDLE: when mem_op=1 and em_addr[1:0]=0, the FSM SHALL latch em_addr, em_wdata and em_memwrite into mem_addr, mem_wdata and mem_we, set mem_req=1 and the counter to 0, and move to WAIT.
REQ-023 IDLE: when mem_op=1 and em_addr[1:0]!=0, align_exc SHALL be 1 and mw_bubble SHALL be 1 for that cycle; stall SHALL be 0, no request SHALL be issued, and the state SHALL remain IDLE.
REQ-024 WAIT: mem_req SHALL stay 1 and the counter SHALL increment each cycle while mem_ack=0.
REQ-025 WAIT with mem_ack=1: read_data SHALL load mem_rdata for a load or hold its value for a store, mem_req SHALL clear, and the FSM SHALL move to DONE.
REQ-026 WAIT with mem_ack=0 and counter=TIMEOUT-1: mem_req SHALL clear, read_data SHALL load 0, bus_err SHALL pulse 1 for the next cycle, and the FSM SHALL move to DONE.
REQ-027 When mem_ack=1 and the timeout arrive in the same cycle, the ack SHALL win and bus_err SHALL stay 0.
REQ-028 DONE SHALL last one cycle, with stall=0 and mw_bubble=0 so that the instruction advances into MEM/WB; the FSM SHALL then return to IDLE unconditionally, with no reissue for the instruction that is leaving.
REQ-029 stall SHALL be 1 in WAIT, and in IDLE when mem_op=1 with an aligned address; it SHALL be 0 otherwise.
REQ-030 mw_bubble SHALL be 1 whenever stall=1, and in the misaligned case.
REQ-031 A non-memory instruction in IDLE SHALL produce stall=0, mw_bubble=0 and zero added latency.
REQ-032 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-033 Minimum memory-op penalty SHALL be 2 stall cycles (ack in the first WAIT cycle); in general it is 1+N cycles for an ack arriving in WAIT cycle N.
REQ-034 mem_addr SHALL be em_addr with bits [1:0] forced to 0.

Reset
REQ-035 While rst_n=0, asynchronously: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read_data=0, bus_err=0.
REQ-036 A reset asserted during WAIT SHALL drop mem_req immediately and abandon the access; a later mem_ack SHALL be ignored.

Verification
REQ-037 Load at 0x100, mem_ack in the first WAIT cycle with rdata=0xDEADBEEF -> stall=1 for 2 cycles, mem_req=1 for 1 cycle, read_data=0xDEADBEEF in DONE, mw_bubble=0 in DONE.
REQ-038 Store at 0x204 with wdata 0x12345678, ack after 3 WAIT cycles -> mem_we=1, mem_addr=0x204, mem_wdata=0x12345678, stall=1 for 4 cycles, read_data unchanged.
REQ-039 Load at 0x102 -> align_exc=1, mw_bubble=1, stall=0, mem_req never asserted.
REQ-040 Load with no ack, TIMEOUT=16 -> mem_req high for 16 cycles, then bus_err=1 for one cycle, read_data=0, FSM returns to IDLE.
REQ-041 rst_n pulled low in the second WAIT cycle, then ack one cycle after release -> mem_req=0 during reset, no DONE, read_data=0, stall=0.
REQ-042 Back-to-back loads (0x10, 0x14), each acked immediately -> two distinct requests, no reissue of the first, 4 total stall cycles.
